// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU op codes, sequencer states
// and the unsupported-op predicate.
package alu_arbiter_pkg;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Codes the ALU has no operation for; it returns zero for them.
  function automatic logic op_unsupported(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// The shared 32-bit ALU: combinational result and Zero flag for an ALUControl code.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  // Operation decode; unsupported codes yield zero.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      OpAdd:   alu_result = a + b;
      OpSub:   alu_result = a - b;
      OpAnd:   alu_result = a & b;
      OpOr:    alu_result = a | b;
      OpSlt:   alu_result = {{(DATA_W-1){1'b0}}, (a < b)};
      OpSll:   alu_result = a << b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared ALU. Each accepted request runs
// IDLE -> EXEC -> RESP; the registered result goes back to the granted port only.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              grant_id,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              rr_ptr_q;
  logic              grant_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, err_q;

  logic              win;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  alu_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a          (a_q),
    .b          (b_q),
    .alu_control(op_q),
    .alu_result (alu_result),
    .zero       (alu_zero)
  );

  // Winner selection: fixed priority favours port 0, otherwise rr_ptr first.
  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO != 0) begin
      win = ~req0_valid;
    end else if (rr_ptr_q ? req1_valid : req0_valid) begin
      win = rr_ptr_q;
    end else begin
      win = ~rr_ptr_q;
    end
  end

  assign accept     = (state_q == StIdle) && (req0_valid || req1_valid);
  assign req0_ready = accept && !win;
  assign req1_ready = accept && win;

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready[grant_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, request capture and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= win;
        op_q    <= win ? req1_op : req0_op;
        a_q     <= win ? req1_a : req0_a;
        b_q     <= win ? req1_b : req0_b;
        if (FIXED_PRIO == 0) rr_ptr_q <= ~win;
      end
      if (state_q == StExec) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        err_q    <= op_unsupported(op_q);
      end
    end
  end

  // Response valid only toward the granted port.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != StIdle);

endmodule
